// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is held in a
// register so rdata is stable while nothing is popped, and keeps its last
// value once the FIFO drains.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CountW-1:0] remain;
  logic [Width-1:0]  rdata_q, rdata_d;
  logic              do_push, do_pop;

  // Qualify push/pop, advance pointers and work out the next head byte.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    do_push  = push && ((count_q != CountW'(Depth)) || do_pop);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    count_d  = count_q + CountW'(do_push) - CountW'(do_pop);
    remain   = count_q - CountW'(do_pop);
    rdata_d  = rdata_q;
    if (count_d != '0) begin
      // When nothing older remains, the byte being written becomes the head.
      rdata_d = (remain == '0) ? wdata : mem_q[rd_ptr_d];
    end
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer, occupancy and head register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small FWFT receive buffer. Detects framing
// errors, buffer overrun and line break (all-zero frame with a low stop bit).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int ClockDivider = 10,
  parameter int Depth        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_bit,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [$clog2(Depth):0] fifo_count,
  output logic                   break_received,
  output logic                   error
);

  localparam int CntW = $clog2(ClockDivider);

  logic                      rx_meta_q, rx_s_q;
  rx_state_t                 state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      brk_q, brk_d;
  logic                      err_q, err_d;
  logic                      sample;
  logic                      push;
  logic                      pop;
  logic                      frame_err;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign pop = data_valid && data_ready;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= input_bit;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic for the receive FSM, bit timer and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    brk_d     = 1'b0;
    sample    = (cnt_q == '0);

    if (state_q == START || state_q == DATA || state_q == STOP) begin
      cnt_d = sample ? CntW'(ClockDivider - 1) : cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          // Half a bit period puts every later sample in mid-bit.
          cnt_d   = CntW'(ClockDivider / 2 - 1);
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else if (shift_q == '0) begin
            brk_d   = 1'b1;
            state_d = BREAK;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      BREAK, WAIT_HIGH: begin
        // Hold here until the line returns high so a long low gives one report.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Overrun: a push into a full buffer with no simultaneous pop is dropped.
    err_d = frame_err || (push && fifo_full && !pop);
  end

  // Receive FSM state and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
      err_q     <= err_d;
    end
  end

  sync_fifo #(
    .Width (UART_DATA_BITS),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (data_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign data_valid     = !fifo_empty;
  assign break_received = brk_q;
  assign error          = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written
// sequences for glitch, long break, overrun/drain and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int CD    = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       input_bit = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] fifo_count;
  logic       break_received;
  logic       error;

  int total = 0;
  int bad   = 0;

  int         valid_cycles;
  int         err_pulses;
  int         brk_pulses;
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_valid;
    logic [7:0] exp_byte;
    int         exp_err;
    int         exp_brk;
  } vec_t;

  vec_t vecs[7];

  uart_rx_fifo #(.ClockDivider(CD), .Depth(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_bit      (input_bit),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .fifo_count     (fifo_count),
    .break_received (break_received),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) valid_cycles++;
      if (error) err_pulses++;
      if (break_received) brk_pulses++;
      if (data_valid && data_ready) rx_q.push_back(data_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit b);
    input_bit = b;
    tick(CD);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    input_bit = 1'b1;
  endtask

  task automatic clear_mon();
    valid_cycles = 0;
    err_pulses   = 0;
    brk_pulses   = 0;
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] d;

    vecs[0] = '{8'h48, 1'b1, 1, 8'h48, 0, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 8'h00, 1, 0};
    vecs[2] = '{8'h41, 1'b1, 1, 8'h41, 0, 0};
    vecs[3] = '{8'h00, 1'b0, 0, 8'h00, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 0};
    vecs[5] = '{8'h00, 1'b1, 1, 8'h00, 0, 0};
    vecs[6] = '{8'h80, 1'b0, 0, 8'h00, 1, 0};
    clear_mon();

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst data_out", data_out, 8'h00);
    check("rst data_valid", data_valid, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst break", break_received, 0);
    check("rst error", error, 0);
    rst = 1'b0;
    tick(2 * CD);

    // Single frames from the table
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop);
      tick(3 * CD);
      check($sformatf("vec%0d valid_cycles", v), valid_cycles, vecs[v].exp_valid);
      if (vecs[v].exp_valid != 0 && rx_q.size() > 0)
        check($sformatf("vec%0d byte", v), rx_q[0], vecs[v].exp_byte);
      check($sformatf("vec%0d error", v), err_pulses, vecs[v].exp_err);
      check($sformatf("vec%0d break", v), brk_pulses, vecs[v].exp_brk);
    end

    // Short low glitch: ignored, receiver returns to idle
    clear_mon();
    input_bit = 1'b0;
    tick(3);
    input_bit = 1'b1;
    tick(3 * CD);
    check("glitch valid", valid_cycles, 0);
    check("glitch error", err_pulses, 0);
    check("glitch break", brk_pulses, 0);
    send_frame(8'h5A, 1'b1);
    tick(3 * CD);
    check("post-glitch count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post-glitch byte", rx_q[0], 8'h5A);

    // Long break: exactly one pulse, then a normal frame
    clear_mon();
    input_bit = 1'b0;
    tick(20 * CD);
    input_bit = 1'b1;
    tick(2 * CD);
    send_frame(8'h41, 1'b1);
    tick(3 * CD);
    check("long break pulses", brk_pulses, 1);
    check("long break error", err_pulses, 0);
    check("after break count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("after break byte", rx_q[0], 8'h41);

    // Overrun: five bytes into a four-entry buffer with the consumer stalled
    clear_mon();
    data_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      d = 8'h41 + 8'(c);
      send_frame(d, 1'b1);
      tick(CD);
    end
    tick(2 * CD);
    check("overrun fifo_count", fifo_count, DEPTH);
    check("overrun error pulses", err_pulses, 1);
    check("overrun data_valid", data_valid, 1);
    check("overrun head", data_out, 8'h41);
    tick(50);
    check("stall head stable", data_out, 8'h41);
    data_ready = 1'b1;
    tick(10);
    check("drain count", rx_q.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'h41 + 8'(k);
      if (k < rx_q.size()) check($sformatf("drain byte%0d", k), rx_q[k], d);
    end
    check("drained fifo_count", fifo_count, 0);
    check("drained data_valid", data_valid, 0);

    // Reset in the middle of data bit 4 with a byte already buffered
    data_ready = 1'b0;
    send_frame(8'h33, 1'b1);
    tick(2 * CD);
    check("pre-reset count", fifo_count, 1);
    d = 8'h7E;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    input_bit = d[4];
    tick(CD / 2);
    rst = 1'b1;
    tick(1);
    check("midrst data_out", data_out, 8'h00);
    check("midrst data_valid", data_valid, 0);
    check("midrst fifo_count", fifo_count, 0);
    check("midrst error", error, 0);
    check("midrst break", break_received, 0);
    rst = 1'b0;
    input_bit = 1'b1;
    tick(2 * CD);
    data_ready = 1'b1;
    clear_mon();
    send_frame(8'h7E, 1'b1);
    tick(3 * CD);
    check("post-reset count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post-reset byte", rx_q[0], 8'h7E);
    check("post-reset error", err_pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
